vending_ctrl: RTL and testbench

Parametrised vending-machine controller and successor to the fixed six-item, 100-unit controller. Item count, coin unit, credit ceiling, price table and stock depth are set by parameters. Adds per-item stock counting, sold-out flags, change return, coin rejection and selection-error reporting. It sits between the coin acceptor/keypad front end and the dispense/change actuators.

---
 rtl/vending_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_vending_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// Parametrised vending-machine controller: coin accumulation, priced selection with
// per-item stock, change return, coin rejection and selection-error reporting.
module vending_ctrl #(
  parameter int NUM_ITEMS  = 6,
  parameter int CREDIT_W   = 11,
  parameter int COIN_UNIT  = 100,
  parameter int MAX_CREDIT = 1000,
  parameter int PRICE_BASE = 500,
  parameter int PRICE_STEP = 100,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3,
  localparam int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic                 coin_valid,
  input  logic [CREDIT_W-1:0]  coin_value,
  input  logic                 sel_valid,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 refund,
  input  logic                 restock,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 done,
  output logic [SEL_W-1:0]     dispense_item,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic                 coin_reject,
  output logic                 sel_error,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Handshakes: every input event is a single-cycle strobe (coin_valid, sel_valid,
  // refund, restock) sampled on the rising edge; there is no back-pressure, so
  // events arriving while busy=1 are rejected (coins) or dropped (others).
  // All outputs are registered; done/change_valid/coin_reject/sel_error are 1-cycle pulses.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic                  r_done;
  logic [SEL_W-1:0]      r_item;
  logic                  r_change_valid;
  logic [CREDIT_W-1:0]   r_change_amt;
  logic                  r_coin_reject;
  logic                  r_sel_error;
  logic [NUM_ITEMS-1:0]  r_sold_out;
  logic                  r_busy;
  logic [STOCK_W-1:0]    r_stock [NUM_ITEMS];

  state_t                w_state_nxt;
  logic [CREDIT_W-1:0]   w_credit_nxt;
  logic                  w_done_nxt;
  logic [SEL_W-1:0]      w_item_nxt;
  logic                  w_change_valid_nxt;
  logic [CREDIT_W-1:0]   w_change_amt_nxt;
  logic                  w_coin_reject_nxt;
  logic                  w_sel_error_nxt;
  logic [NUM_ITEMS-1:0]  w_sold_out_nxt;
  logic [STOCK_W-1:0]    w_stock_nxt [NUM_ITEMS];

  logic [STOCK_W-1:0]    w_sel_stock;
  logic                  w_sel_in_range;
  logic [31:0]           w_price;
  logic                  w_sel_ok;
  logic [CREDIT_W:0]     w_coin_sum;
  logic                  w_coin_ok;

  // Selection and coin qualification, evaluated wide enough that nothing wraps.
  always_comb begin
    w_sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) w_sel_stock = r_stock[i];
    end
    w_sel_in_range = (32'(sel) < 32'(NUM_ITEMS));
    w_price        = 32'(PRICE_BASE) + 32'(sel) * 32'(PRICE_STEP);
    w_sel_ok       = w_sel_in_range && (w_sel_stock != '0) && (32'(r_credit) >= w_price);
    w_coin_sum     = {1'b0, r_credit} + {1'b0, coin_value};
    w_coin_ok      = (coin_value != '0) &&
                     ((32'(coin_value) % 32'(COIN_UNIT)) == 32'd0) &&
                     (32'(w_coin_sum) <= 32'(MAX_CREDIT));
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_done_nxt         = 1'b0;
    w_item_nxt         = r_item;
    w_change_valid_nxt = 1'b0;
    w_change_amt_nxt   = r_change_amt;
    w_coin_reject_nxt  = 1'b0;
    w_sel_error_nxt    = 1'b0;
    w_stock_nxt        = r_stock;
    w_sold_out_nxt     = '0;

    case (r_state)
      S_IDLE, S_CREDIT: begin
        if (refund) begin
          w_coin_reject_nxt = coin_valid;
          if (r_state == S_CREDIT) begin
            w_state_nxt        = S_CHANGE;
            w_change_valid_nxt = 1'b1;
            w_change_amt_nxt   = r_credit;
            w_credit_nxt       = '0;
          end
        end else if (sel_valid) begin
          w_coin_reject_nxt = coin_valid;
          if (!w_sel_ok) begin
            w_sel_error_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_DISPENSE;
            w_done_nxt   = 1'b1;
            w_item_nxt   = sel;
            w_credit_nxt = r_credit - w_price[CREDIT_W-1:0];
            for (int i = 0; i < NUM_ITEMS; i++) begin
              if (sel == SEL_W'(i)) w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
            end
          end
        end else if (coin_valid) begin
          if (w_coin_ok) begin
            w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
            w_state_nxt  = S_CREDIT;
          end else begin
            w_coin_reject_nxt = 1'b1;
          end
        end
        // Restock overrides any decrement taken in the same cycle.
        if (restock) begin
          for (int i = 0; i < NUM_ITEMS; i++) w_stock_nxt[i] = STOCK_W'(STOCK_INIT);
        end
      end
      S_DISPENSE: begin
        w_coin_reject_nxt = coin_valid;
        if (r_credit != '0) begin
          w_state_nxt        = S_CHANGE;
          w_change_valid_nxt = 1'b1;
          w_change_amt_nxt   = r_credit;
          w_credit_nxt       = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_coin_reject_nxt = coin_valid;
        w_state_nxt       = S_IDLE;
      end
    endcase

    for (int i = 0; i < NUM_ITEMS; i++) w_sold_out_nxt[i] = (w_stock_nxt[i] == '0);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_done         <= 1'b0;
      r_item         <= '0;
      r_change_valid <= 1'b0;
      r_change_amt   <= '0;
      r_coin_reject  <= 1'b0;
      r_sel_error    <= 1'b0;
      r_busy         <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        r_stock[i]    <= STOCK_W'(STOCK_INIT);
        r_sold_out[i] <= (STOCK_INIT == 0);
      end
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_done         <= w_done_nxt;
      r_item         <= w_item_nxt;
      r_change_valid <= w_change_valid_nxt;
      r_change_amt   <= w_change_amt_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_sel_error    <= w_sel_error_nxt;
      r_busy         <= (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
      r_stock        <= w_stock_nxt;
      r_sold_out     <= w_sold_out_nxt;
    end
  end

  assign credit        = r_credit;
  assign done          = r_done;
  assign dispense_item = r_item;
  assign change_valid  = r_change_valid;
  assign change_amt    = r_change_amt;
  assign coin_reject   = r_coin_reject;
  assign sel_error     = r_sel_error;
  assign sold_out      = r_sold_out;
  assign busy          = r_busy;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: directed coin/selection/refund scenarios with a
// reference model feeding expected pulse queues that a negedge monitor drains.
module tb_vending_ctrl;

  localparam int CW = 11;
  localparam int NI = 6;

  logic          clock;
  logic          n_reset;
  logic          coin_valid;
  logic [CW-1:0] coin_value;
  logic          sel_valid;
  logic [2:0]    sel;
  logic          refund;
  logic          restock;
  logic [CW-1:0] credit;
  logic          done;
  logic [2:0]    dispense_item;
  logic          change_valid;
  logic [CW-1:0] change_amt;
  logic          coin_reject;
  logic          sel_error;
  logic [NI-1:0] sold_out;
  logic          busy;
  logic [1:0]    state_dbg;

  vending_ctrl dut (
    .clock(clock), .n_reset(n_reset),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel(sel),
    .refund(refund), .restock(restock),
    .credit(credit), .done(done), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .sel_error(sel_error),
    .sold_out(sold_out), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: expected pulses
  logic [CW-1:0] done_q[$];
  logic [CW-1:0] chg_q[$];
  int            rej_pending  = 0;
  int            serr_pending = 0;

  // reference model
  int m_credit = 0;
  int m_stock[NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [NI-1:0] model_sold();
    logic [NI-1:0] s;
    for (int i = 0; i < NI; i++) s[i] = (m_stock[i] == 0);
    return s;
  endfunction

  always @(negedge clock) begin
    if (n_reset) begin
      if (done) begin
        check("done_pending", 32'(done_q.size() > 0), 1);
        if (done_q.size() > 0) check("done_item", 32'(dispense_item), 32'(done_q.pop_front()));
      end
      if (change_valid) begin
        check("chg_pending", 32'(chg_q.size() > 0), 1);
        if (chg_q.size() > 0) check("chg_amt", 32'(change_amt), 32'(chg_q.pop_front()));
      end
      if (coin_reject) begin
        check("rej_pending", 32'(rej_pending > 0), 1);
        if (rej_pending > 0) rej_pending--;
      end
      if (sel_error) begin
        check("serr_pending", 32'(serr_pending > 0), 1);
        if (serr_pending > 0) serr_pending--;
      end
    end
  end

  // driver: one cycle of stimulus in IDLE/CREDIT, with model update and expectation pushes
  task automatic step(input logic cv, input int cval, input logic sv, input int s,
                      input logic rf, input logic rs);
    int price;
    int cred_edge;
    coin_valid = cv; coin_value = CW'(cval); sel_valid = sv; sel = 3'(s);
    refund = rf; restock = rs;
    cred_edge = m_credit;
    if (rf) begin
      if (cv) rej_pending++;
      if (m_credit > 0) chg_q.push_back(CW'(m_credit));
      cred_edge = 0;
      m_credit  = 0;
    end else if (sv) begin
      if (cv) rej_pending++;
      price = 500 + 100 * s;
      if (s >= NI || m_stock[s] == 0 || m_credit < price) begin
        serr_pending++;
      end else begin
        done_q.push_back(CW'(s));
        m_stock[s]--;
        cred_edge = m_credit - price;
        if (cred_edge > 0) chg_q.push_back(CW'(cred_edge));
        m_credit = 0;
      end
    end else if (cv) begin
      if (cval != 0 && cval % 100 == 0 && m_credit + cval <= 1000) m_credit += cval;
      else rej_pending++;
      cred_edge = m_credit;
    end
    if (rs) for (int i = 0; i < NI; i++) m_stock[i] = 3;
    @(posedge clock); #1;
    coin_valid = 0; coin_value = '0; sel_valid = 0; sel = '0; refund = 0; restock = 0;
    check("credit", 32'(credit), 32'(cred_edge));
    check("sold_out", 32'(sold_out), 32'(model_sold()));
  endtask

  task automatic coin(input int v);
    step(1'b1, v, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic pick(input int s);
    step(1'b0, 0, 1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) m_stock[i] = 3;
    n_reset = 0; coin_valid = 0; coin_value = '0; sel_valid = 0; sel = '0;
    refund = 0; restock = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_credit", 32'(credit), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sold_out", 32'(sold_out), 0);
    check("rst_state", 32'(state_dbg), 0);
    n_reset = 1;
    idle(1);

    // refund in IDLE: no pulse
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);

    // exact payment, no change
    coin(200);
    check("credit_200", 32'(credit), 200);
    check("state_credit", 32'(state_dbg), 1);
    coin(300);
    check("credit_500", 32'(credit), 500);
    pick(0);
    check("done_lat1", 32'(done), 1);
    check("busy_disp", 32'(busy), 1);
    idle(1);
    check("no_chg", 32'(change_valid), 0);
    check("idle_after", 32'(state_dbg), 0);

    // over-payment with change two cycles after accept
    coin(500); coin(500);
    pick(2);
    check("chg_not_yet", 32'(change_valid), 0);
    idle(1);
    check("chg_lat2", 32'(change_valid), 1);
    check("chg_300", 32'(change_amt), 300);
    check("busy_chg", 32'(busy), 1);
    idle(1);
    check("idle_after_chg", 32'(state_dbg), 0);
    check("chg_amt_hold", 32'(change_amt), 300);

    // coin rejections
    coin(500); coin(400);
    coin(200);
    check("credit_900", 32'(credit), 900);
    coin(150);
    coin(0);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    idle(2);

    // sell out item 1, then refused, then restock
    for (int k = 0; k < 3; k++) begin
      coin(500); coin(500); pick(1); idle(2);
    end
    check("sold_out1", 32'(sold_out[1]), 1);
    coin(500); coin(500);
    pick(1);
    check("credit_kept", 32'(credit), 1000);
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    check("restock_clear", 32'(sold_out), 0);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    idle(2);

    // insufficient credit and out-of-range selection
    coin(300);
    pick(3);
    pick(7);
    step(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    idle(2);

    // coin during DISPENSE is rejected
    coin(500); coin(100);
    pick(0);
    coin_valid = 1; coin_value = CW'(100); rej_pending++;
    idle(1);
    coin_valid = 0; coin_value = '0;
    idle(1);

    // refund beats sel and coin in the same cycle
    coin(500); coin(100);
    step(1'b1, $urandom_range(1, 5) * 100, 1'b1, 0, 1'b1, 1'b0);
    idle(2);

    // reset in the middle of a dispense
    coin(500); coin(500);
    pick(0);
    n_reset = 0;
    #2;
    check("mid_rst_credit", 32'(credit), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_state", 32'(state_dbg), 0);
    check("mid_rst_sold", 32'(sold_out), 0);
    check("mid_rst_item", 32'(dispense_item), 0);
    check("mid_rst_amt", 32'(change_amt), 0);
    done_q.delete(); chg_q.delete(); rej_pending = 0; serr_pending = 0;
    m_credit = 0;
    for (int i = 0; i < NI; i++) m_stock[i] = 3;
    @(negedge clock);
    n_reset = 1;
    idle(3);
    check("post_rst_chg", 32'(change_valid), 0);

    // stock is back to full: item 0 sells three times
    for (int k = 0; k < 3; k++) begin
      coin(500); pick(0); idle(1);
    end
    check("item0_out", 32'(sold_out[0]), 1);

    check("done_q_empty", 32'(done_q.size()), 0);
    check("chg_q_empty", 32'(chg_q.size()), 0);
    check("rej_drained", 32'(rej_pending), 0);
    check("serr_drained", 32'(serr_pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
